restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
- Sequential unsigned integer divider. Computes quotient and remainder by shift-and-subtract, one quotient bit per clock.
- Inverse companion to the team's 4-bit multi-operand adder datapath. It sits in the same arithmetic library and reuses the existing `fulladder` cell as its subtract primitive.
- Single-request start/done handshake, so a controller or testbench can drive it directly.

Parameters:
- W, 4, operand width in bits for dividend, divisor, quotient and remainder (W >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  W  numerator, captured on accepted start
- divisor  input  W  denominator, captured on accepted start
- busy  output  1  high from the cycle after accepted start until done is asserted
- done  output  1  one-cycle pulse; results valid in the same cycle
- quotient  output  W  result, held until next accepted start
- remainder  output  W  result, held until next accepted start
- div_by_zero  output  1  set with done when divisor==0; held with results

Behaviour:
- Reset is asynchronous, active-low. All outputs go to 0, internal registers go to 0, and the FSM goes to IDLE.
- Reset asserted mid-operation aborts the division. No done is produced for the aborted request.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 and divisor!=0: latch operands, set R=0, set Q=dividend, set count=W-1, go to CALC. quotient, remainder and div_by_zero are not altered until DONE.
  - start=1 and divisor==0: go to DONE with quotient={W{1'b1}}, remainder=dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- CALC, one iteration per cycle:
  - Form the trial value T = {R[W-1:0], Q[W-1]}, W+1 bits.
  - Shift Q left by one.
  - Compute D = T - {1'b0, divisor}.
  - If D is non-negative (borrow-out = 0): R = D and Q[0] = 1. Otherwise: R = T and Q[0] = 0.
  - When count==0, go to DONE; otherwise decrement count.
- DONE:
  - done=1 for exactly one cycle.
  - For a normal division: quotient=Q, remainder=R[W-1:0], div_by_zero=0.
  - Return to IDLE.
  - start in this cycle is ignored.
- Latency: start accepted at cycle 0.
  - Normal division: busy=1 in cycles 1..W, done=1 in cycle W+1.
  - Divide-by-zero: busy stays 0 and done=1 in cycle 1.
- Back-to-back operation: the earliest next accept is the cycle after done (cycle W+2).
- start while busy or in DONE is ignored. Operand inputs may change freely after the accept cycle.
- Width and arithmetic rules:
  - The partial remainder is W+1 bits, so no overflow occurs.
  - The subtraction is two's-complement, A + ~B + 1, with carry-in = 1. Carry-out = 1 means non-negative.
  - Invariant at done: dividend == quotient*divisor + remainder, and remainder < divisor.
- Boundary cases:
  - dividend < divisor gives quotient=0 and remainder=dividend.
  - divisor=1 gives quotient=dividend and remainder=0.
  - dividend=0 gives 0/0 with no divide-by-zero flag, provided divisor!=0.

Decomposition:
- Shared package `arith_pkg`:
  - FSM state enum `div_state_t` (IDLE, CALC, DONE)
  - constant `DIV_ZERO_QUOTIENT` = all ones
  - width of the count register as $clog2(W)
- Sub-module `ripple_subtractor`:
  - (W+1)-bit subtractor built from a chain of the existing `fulladder` cells, with B inverted and carry-in = 1.
  - Outputs difference and borrow_n (the carry-out).
  - Instantiated once by `restoring_divider`.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- W=4, reset, then start with dividend=13, divisor=4 -> busy in cycles 1-4; done in cycle 5 with quotient=3, remainder=1, div_by_zero=0.
- Start with 15/1, then 15/15, then 3/7 back-to-back at the earliest accept -> results (15,0), (1,0), (3 gives quotient=0, remainder=3). Each done is exactly one cycle wide.
- Start with 9/0 -> done in cycle 1 with quotient=15, remainder=9, div_by_zero=1, and busy never asserted. A following 6/3 -> quotient=2, remainder=0, div_by_zero cleared.
- Start with 14/3, pulse start with 1/1 during cycles 2 and 5, and change the operand inputs during CALC -> single done with quotient=4, remainder=2. The second request is ignored.
- Start with 12/5, assert rst_n=0 asynchronously mid-cycle 2 -> all outputs 0 immediately and no done pulse. After release, 12/5 -> quotient=2, remainder=2.
- Random sweep of all 256 operand pairs for W=4, plus a W=8 random set -> for every divisor!=0, dividend == quotient*divisor + remainder and remainder < divisor.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic library: divider FSM states and
// width helpers.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  // Sliced to the operand width by the user; covers widths up to 64 bits.
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

  function automatic int count_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell shared across the arithmetic library.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_subtractor.sv
// N-bit subtractor a - b as a + ~b + 1 over a fulladder ripple chain.
// borrow_n_o is the final carry-out: 1 means the difference is non-negative.
module ripple_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_n_o
);

  logic [N:0]   carry;
  logic [N-1:0] b_inv;

  assign carry[0] = 1'b1;
  assign b_inv    = ~b_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fulladder u_fa (
      .a   (a_i[i]),
      .b   (b_inv[i]),
      .cin (carry[i]),
      .sum (diff_o[i]),
      .cout(carry[i+1])
    );
  end

  assign borrow_n_o = carry[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with a start/done handshake and divide-by-zero short cut.
module restoring_divider
  import arith_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = count_width(W);

  div_state_t    state_q;
  logic [W-1:0]  r_q, q_q, divisor_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, dbz_q;
  logic [W-1:0]  quotient_q, remainder_q;

  logic [W:0]    trial, diff;
  logic          borrow_n;
  logic [W-1:0]  r_d, q_d;
  logic          diff_msb_unused;

  assign trial = {r_q, q_q[W-1]};

  ripple_subtractor #(.N(W + 1)) u_sub (
    .a_i       (trial),
    .b_i       ({1'b0, divisor_q}),
    .diff_o    (diff),
    .borrow_n_o(borrow_n)
  );

  // A kept difference is below the divisor, so its top bit is always zero.
  assign diff_msb_unused = diff[W];
  assign r_d = borrow_n ? diff[W-1:0] : trial[W-1:0];
  assign q_d = {q_q[W-2:0], borrow_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              divisor_q <= divisor;
              r_q       <= '0;
              q_q       <= dividend;
              cnt_q     <= CW'(W - 1);
              busy_q    <= 1'b1;
              state_q   <= CALC;
            end else begin
              quotient_q  <= DIV_ZERO_QUOTIENT[W-1:0];
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        CALC: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= r_d;
            dbz_q       <= 1'b0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider at W=4 and W=8: directed table,
// handshake corner sequences, exhaustive W=4 sweep and random W=8 set.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, busy4, done4, z4;
  logic [3:0] dd4, dv4, q4, r4;
  logic       start8, busy8, done8, z8;
  logic [7:0] dd8, dv8, q8, r8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  restoring_divider #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dd4), .divisor(dv4),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
  );

  restoring_divider #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dd8), .divisor(dv8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  typedef struct {
    logic [3:0] a, b, q, r;
    logic       z;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer division; divisor 0 yields all-ones, dividend, flag.
  function automatic void ref_div(input int w, input int a, input int b,
                                  output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << w) - 1; r = a; z = 1;
    end else begin
      q = a / b; r = a % b; z = 0;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input int exp_lat,
                        output logic [3:0] q, output logic [3:0] r, output logic z);
    logic [3:0] pq, pr;
    logic       pz;
    int         cyc;
    bit         seen;
    pq = q4; pr = r4; pz = z4;
    start4 = 1'b1; dd4 = a; dv4 = b;
    @(negedge clk);
    cyc = 1; seen = 0;
    start4 = 1'b0; dd4 = 4'($urandom); dv4 = 4'($urandom);
    while (!seen && cyc <= 20) begin
      chk("busy4", busy4, 32'(cyc < exp_lat));
      if (done4) seen = 1;
      else begin
        chk("hold_q4", q4, pq); chk("hold_r4", r4, pr); chk("hold_z4", z4, pz);
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen4", 32'(seen), 1);
    chk("latency4", cyc, exp_lat);
    q = q4; r = r4; z = z4;
    @(negedge clk);
    chk("done_width4", done4, 0);
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                        output logic [7:0] q, output logic [7:0] r, output logic z);
    int cyc;
    bit seen;
    start8 = 1'b1; dd8 = a; dv8 = b;
    @(negedge clk);
    cyc = 1; seen = 0;
    start8 = 1'b0; dd8 = 8'($urandom); dv8 = 8'($urandom);
    while (!seen && cyc <= 30) begin
      if (done8) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("latency8", cyc, exp_lat);
    q = q8; r = r8; z = z8;
    @(negedge clk);
    chk("done_width8", done8, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[8];
    logic [3:0] q, r;
    logic [7:0] q8v, r8v;
    logic       z;
    int         order[256];
    int         eq, er, ez, a, b, j, tmp;

    vt[0] = '{a: 13, b: 4,  q: 3,  r: 1, z: 0, lat: 5};
    vt[1] = '{a: 15, b: 1,  q: 15, r: 0, z: 0, lat: 5};
    vt[2] = '{a: 15, b: 15, q: 1,  r: 0, z: 0, lat: 5};
    vt[3] = '{a: 3,  b: 7,  q: 0,  r: 3, z: 0, lat: 5};
    vt[4] = '{a: 9,  b: 0,  q: 15, r: 9, z: 1, lat: 1};
    vt[5] = '{a: 6,  b: 3,  q: 2,  r: 0, z: 0, lat: 5};
    vt[6] = '{a: 0,  b: 5,  q: 0,  r: 0, z: 0, lat: 5};
    vt[7] = '{a: 11, b: 2,  q: 5,  r: 1, z: 0, lat: 5};

    rst_n = 1'b0;
    start4 = 1'b0; dd4 = '0; dv4 = '0;
    start8 = 1'b0; dd8 = '0; dv8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy4, 0); chk("rst_done", done4, 0);
    chk("rst_q", q4, 0); chk("rst_r", r4, 0); chk("rst_z", z4, 0);
    chk("rst_busy8", busy8, 0); chk("rst_done8", done8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back to back at the earliest accept.
    for (int i = 0; i < 8; i++) begin
      do_op4(vt[i].a, vt[i].b, vt[i].lat, q, r, z);
      chk("tbl_q", q, vt[i].q);
      chk("tbl_r", r, vt[i].r);
      chk("tbl_z", z, vt[i].z);
    end

    // Start pulses during CALC and DONE are ignored; operands wiggle.
    start4 = 1'b1; dd4 = 14; dv4 = 3;
    @(negedge clk); start4 = 1'b0; dd4 = 1; dv4 = 1;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; dd4 = 4'($urandom); dv4 = 4'($urandom);
    @(negedge clk);
    @(negedge clk);
    chk("ign_done", done4, 1); chk("ign_q", q4, 4); chk("ign_r", r4, 2); chk("ign_z", z4, 0);
    start4 = 1'b1; dd4 = 1; dv4 = 1;
    @(negedge clk); start4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("ign_no_done", done4, 0);
      chk("ign_no_busy", busy4, 0);
      @(negedge clk);
    end
    chk("ign_q_held", q4, 4);

    // Asynchronous reset mid-operation aborts with no done.
    start4 = 1'b1; dd4 = 12; dv4 = 5;
    @(negedge clk); start4 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy4, 0); chk("abort_done", done4, 0);
    chk("abort_q", q4, 0); chk("abort_r", r4, 0); chk("abort_z", z4, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", done4, 0);
      @(negedge clk);
    end
    do_op4(4'd12, 4'd5, 5, q, r, z);
    chk("post_rst_q", q, 2); chk("post_rst_r", r, 2); chk("post_rst_z", z, 0);

    // Every W=4 operand pair in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      a = order[i] >> 4;
      b = order[i] & 15;
      ref_div(4, a, b, eq, er, ez);
      do_op4(4'(a), 4'(b), (b == 0) ? 1 : 5, q, r, z);
      chk("sw_q", q, eq); chk("sw_r", r, er); chk("sw_z", z, ez);
      if (b != 0) begin
        chk("sw_inv", int'(q) * b + int'(r), a);
        chk("sw_rem_lt", 32'(int'(r) < b), 1);
      end
    end

    // Random W=8 set.
    for (int i = 0; i < 120; i++) begin
      a = int'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       b = 0;
        1, 2:    b = int'($urandom_range(1, 15));
        default: b = int'($urandom_range(1, 255));
      endcase
      ref_div(8, a, b, eq, er, ez);
      do_op8(8'(a), 8'(b), (b == 0) ? 1 : 9, q8v, r8v, z);
      chk("w8_q", q8v, eq); chk("w8_r", r8v, er); chk("w8_z", z, ez);
      if (b != 0) begin
        chk("w8_inv", int'(q8v) * b + int'(r8v), a);
        chk("w8_rem_lt", 32'(int'(r8v) < b), 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
